// File: rtl/kbd_proto_pkg.sv
// Shared opcodes, state encoding and helpers for the Archimedes keyboard-side protocol.
// Imported by the responder; values follow the IOC keyboard link byte set.
package kbd_proto_pkg;

   localparam logic [7:0] HRST = 8'hFF;
   localparam logic [7:0] RAK1 = 8'hFE;
   localparam logic [7:0] RAK2 = 8'hFD;
   localparam logic [7:0] RQID = 8'h20;
   localparam logic [7:0] PRST = 8'h21;
   localparam logic [7:0] RQMP = 8'h22;
   localparam logic [7:0] BACK = 8'h3F;
   localparam logic [7:0] NACK = 8'h30;
   localparam logic [7:0] SACK = 8'h31;
   localparam logic [7:0] MACK = 8'h32;
   localparam logic [7:0] SMAK = 8'h33;
   localparam logic [7:0] KDDA = 8'hC0;
   localparam logic [7:0] KUDA = 8'hD0;

   typedef enum logic [3:0] {
      WAIT_HRST  = 4'd0,
      WAIT_RAK1  = 4'd1,
      WAIT_RAK2  = 4'd2,
      IDLE       = 4'd3,
      SEND_K1    = 4'd4,
      WAIT_BACK  = 4'd5,
      SEND_K2    = 4'd6,
      WAIT_KACK  = 4'd7,
      SEND_MX    = 4'd8,
      WAIT_MBACK = 4'd9,
      SEND_MY    = 4'd10,
      WAIT_MACK  = 4'd11
   } kbd_state_e;

   // NACK/SACK/MACK/SMAK share the 0011_00xx pattern; bit0 = scan, bit1 = mouse.
   function automatic logic is_ack(input logic [7:0] b);
      return (b[7:2] == 6'b001100);
   endfunction

   function automatic logic is_leds(input logic [7:0] b);
      return (b[7:3] == 5'b00000);
   endfunction

   // 7-bit signed accumulate with clamp to -64..+63.
   function automatic logic [6:0] sat_add(input logic [6:0] acc, input logic [7:0] d);
      logic signed [8:0] sum;
      sum = $signed({{2{acc[6]}}, acc}) + $signed({d[7], d});
      if (sum > 9'sd63) begin
         return 7'h3F;
      end else if (sum < -9'sd64) begin
         return 7'h40;
      end else begin
         return sum[6:0];
      end
   endfunction

endpackage

// File: rtl/kbd_event_fifo.sv
// Synchronous key-event FIFO {down,row,col}; head is visible while non-empty.
// Push while full is accepted when a pop happens in the same cycle.
module kbd_event_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign do_pop_s  = pop && !empty;
   assign do_push_s = push && (!full || do_pop_s);
   assign head      = mem_r[rd_ptr_r[AW-1:0]];

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push_s && !flush) begin
         mem_r[wr_ptr_r[AW-1:0]] <= push_data;
      end
   end

   // Pointer update; flush empties in one cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
      end else begin
         if (do_push_s) wr_ptr_r <= wr_ptr_r + 1'b1;
         if (do_pop_s)  rd_ptr_r <= rd_ptr_r + 1'b1;
      end
   end

endmodule

// File: rtl/kbd_responder.sv
// Keyboard end of the Archimedes serial keyboard link: reset handshake, ID, LEDs,
// key and mouse reports with per-byte acknowledge, paced by a transmit gap counter.
module kbd_responder
   import kbd_proto_pkg::*;
#(
   parameter int         FIFO_DEPTH = 8,
   parameter int         TX_GAP     = 64,
   parameter logic [7:0] KBD_ID     = 8'h81
) (
   input  logic       clkcpu,
   input  logic       rst_n,
   input  logic [7:0] kbd_out_data,
   input  logic       kbd_out_strobe,
   output logic [7:0] kbd_in_data,
   output logic       kbd_in_strobe,
   input  logic       key_valid,
   input  logic       key_down,
   input  logic [3:0] key_row,
   input  logic [3:0] key_col,
   output logic       key_ready,
   input  logic [7:0] mouse_dx,
   input  logic [7:0] mouse_dy,
   input  logic       mouse_stb,
   output logic [2:0] leds
);
   localparam int GW = $clog2(TX_GAP) + 1;

   kbd_state_e state_r, state_nxt_s;
   logic [GW-1:0] gap_r;
   logic          pend_valid_r;
   logic [7:0]    pend_data_r;
   logic [7:0]    kbd_in_data_r;
   logic          kbd_in_strobe_r;
   logic [2:0]    leds_r;
   logic          scan_en_r, mouse_en_r, rqmp_r;
   logic [6:0]    acc_x_r, acc_y_r, snap_x_r, snap_y_r;

   logic          rx_s, hrst_s, slot_free_s, emit_s;
   logic          is_leds_s, is_ack_s, side_cmd_s, mouse_due_s;
   logic          load_s, rqid_load_s, flush_s, pop_s, cmd_en_s, ack_take_s, start_mouse_s;
   logic [7:0]    load_data_s;
   logic          push_s, fifo_full_s, fifo_empty_s;
   logic [8:0]    head_s;
   logic [3:0]    key_nib_s;

   assign kbd_in_data   = kbd_in_data_r;
   assign kbd_in_strobe = kbd_in_strobe_r;
   assign leds          = leds_r;
   assign key_ready     = !fifo_full_s;
   assign push_s        = key_valid && key_ready;

   assign rx_s        = kbd_out_strobe;
   assign hrst_s      = rx_s && (kbd_out_data == HRST);
   assign slot_free_s = !pend_valid_r || (gap_r == {GW{1'b0}});
   assign emit_s      = pend_valid_r && (gap_r == {GW{1'b0}}) && !hrst_s;
   assign is_leds_s   = is_leds(kbd_out_data);
   assign is_ack_s    = is_ack(kbd_out_data);
   assign side_cmd_s  = is_leds_s || (kbd_out_data == RQID);
   assign mouse_due_s = (acc_x_r != 7'd0) || (acc_y_r != 7'd0) || rqmp_r;
   assign key_nib_s   = head_s[8] ? KDDA[7:4] : KUDA[7:4];
   assign rqid_load_s = cmd_en_s && (kbd_out_data == RQID) && slot_free_s;

   kbd_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (9)
   ) u_fifo (
      .clk       (clkcpu),
      .rst_n     (rst_n),
      .flush     (flush_s),
      .push      (push_s),
      .push_data ({key_down, key_row, key_col}),
      .pop       (pop_s),
      .head      (head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   // State register
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) state_r <= WAIT_HRST;
      else        state_r <= state_nxt_s;
   end

   // Protocol next-state and reply selection; HRST overrides everything
   always_comb begin
      state_nxt_s   = state_r;
      load_s        = 1'b0;
      load_data_s   = 8'h00;
      flush_s       = 1'b0;
      pop_s         = 1'b0;
      cmd_en_s      = 1'b0;
      ack_take_s    = 1'b0;
      start_mouse_s = 1'b0;
      if (hrst_s) begin
         flush_s     = 1'b1;
         load_s      = 1'b1;
         load_data_s = HRST;
         state_nxt_s = WAIT_RAK1;
      end else begin
         case (state_r)
            WAIT_HRST: state_nxt_s = WAIT_HRST;
            WAIT_RAK1, WAIT_RAK2: begin
               if (rx_s) begin
                  load_s = slot_free_s;
                  if (state_r == WAIT_RAK1 && kbd_out_data == RAK1) begin
                     load_data_s = RAK1;
                     state_nxt_s = WAIT_RAK2;
                  end else if (state_r == WAIT_RAK2 && kbd_out_data == RAK2) begin
                     load_data_s = RAK2;
                     state_nxt_s = IDLE;
                  end else begin
                     load_data_s = HRST;
                     state_nxt_s = WAIT_RAK1;
                  end
               end else begin
                  state_nxt_s = state_r;
               end
            end
            IDLE: begin
               if (rx_s) begin
                  cmd_en_s = 1'b1;
               end else if (scan_en_r && !fifo_empty_s) begin
                  state_nxt_s = SEND_K1;
               end else if (mouse_en_r && mouse_due_s) begin
                  start_mouse_s = 1'b1;
                  state_nxt_s   = SEND_MX;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            SEND_K1, SEND_K2, SEND_MX, SEND_MY: begin
               if (slot_free_s) begin
                  load_s = 1'b1;
                  case (state_r)
                     SEND_K1: begin load_data_s = {key_nib_s, head_s[7:4]}; state_nxt_s = WAIT_BACK;  end
                     SEND_K2: begin load_data_s = {key_nib_s, head_s[3:0]}; state_nxt_s = WAIT_KACK;  end
                     SEND_MX: begin load_data_s = {1'b0, snap_x_r};         state_nxt_s = WAIT_MBACK; end
                     default: begin load_data_s = {1'b0, snap_y_r};         state_nxt_s = WAIT_MACK;  end
                  endcase
               end else begin
                  state_nxt_s = state_r;
               end
            end
            WAIT_BACK, WAIT_MBACK: begin
               if (!rx_s) begin
                  state_nxt_s = state_r;
               end else if (kbd_out_data == BACK) begin
                  state_nxt_s = (state_r == WAIT_BACK) ? SEND_K2 : SEND_MY;
               end else if (side_cmd_s) begin
                  cmd_en_s = 1'b1;
               end else begin
                  state_nxt_s = (state_r == WAIT_BACK) ? SEND_K1 : SEND_MX;
               end
            end
            WAIT_KACK, WAIT_MACK: begin
               if (!rx_s) begin
                  state_nxt_s = state_r;
               end else if (is_ack_s) begin
                  ack_take_s  = 1'b1;
                  pop_s       = (state_r == WAIT_KACK);
                  state_nxt_s = IDLE;
               end else if (side_cmd_s) begin
                  cmd_en_s = 1'b1;
               end else begin
                  state_nxt_s = (state_r == WAIT_KACK) ? SEND_K1 : SEND_MX;
               end
            end
            default: state_nxt_s = WAIT_HRST;
         endcase
      end
   end

   // Single-byte reply slot, gap pacing and strobe generation
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         gap_r           <= {GW{1'b0}};
         pend_valid_r    <= 1'b0;
         pend_data_r     <= 8'h00;
         kbd_in_data_r   <= 8'h00;
         kbd_in_strobe_r <= 1'b0;
      end else begin
         kbd_in_strobe_r <= emit_s;
         if (emit_s) begin
            kbd_in_data_r <= pend_data_r;
            gap_r         <= GW'(TX_GAP - 1);
         end else if (gap_r != {GW{1'b0}}) begin
            gap_r <= gap_r - 1'b1;
         end
         if (load_s) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= load_data_s;
         end else if (rqid_load_s) begin
            pend_valid_r <= 1'b1;
            pend_data_r  <= KBD_ID;
         end else if (emit_s) begin
            pend_valid_r <= 1'b0;
         end
      end
   end

   // Host-controlled LED, enable and forced-mouse-report flags
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         leds_r     <= 3'b000;
         scan_en_r  <= 1'b0;
         mouse_en_r <= 1'b0;
         rqmp_r     <= 1'b0;
      end else if (flush_s) begin
         scan_en_r  <= 1'b0;
         mouse_en_r <= 1'b0;
         rqmp_r     <= 1'b0;
      end else begin
         if (cmd_en_s && is_leds_s) leds_r <= kbd_out_data[2:0];
         if ((cmd_en_s && is_ack_s) || ack_take_s) begin
            scan_en_r  <= kbd_out_data[0];
            mouse_en_r <= kbd_out_data[1];
         end
         if (start_mouse_s)                            rqmp_r <= 1'b0;
         else if (cmd_en_s && kbd_out_data == RQMP)    rqmp_r <= 1'b1;
      end
   end

   // Mouse accumulators: snapshot moves the whole balance into the report
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         acc_x_r  <= 7'd0;
         acc_y_r  <= 7'd0;
         snap_x_r <= 7'd0;
         snap_y_r <= 7'd0;
      end else if (flush_s) begin
         acc_x_r <= 7'd0;
         acc_y_r <= 7'd0;
      end else if (start_mouse_s) begin
         snap_x_r <= acc_x_r;
         snap_y_r <= acc_y_r;
         acc_x_r  <= mouse_stb ? sat_add(7'd0, mouse_dx) : 7'd0;
         acc_y_r  <= mouse_stb ? sat_add(7'd0, mouse_dy) : 7'd0;
      end else if (mouse_stb) begin
         acc_x_r <= sat_add(acc_x_r, mouse_dx);
         acc_y_r <= sat_add(acc_y_r, mouse_dy);
      end
   end

endmodule

// File: tb/tb_kbd_responder.sv
// Directed self-checking bench for kbd_responder with TX_GAP=4, FIFO_DEPTH=8.
module tb_kbd_responder;
   logic       clkcpu = 1'b0;
   logic       rst_n  = 1'b0;
   logic [7:0] kbd_out_data = 8'h00;
   logic       kbd_out_strobe = 1'b0;
   logic [7:0] kbd_in_data;
   logic       kbd_in_strobe;
   logic       key_valid = 1'b0, key_down = 1'b0;
   logic [3:0] key_row = 4'h0, key_col = 4'h0;
   logic       key_ready;
   logic [7:0] mouse_dx = 8'h00, mouse_dy = 8'h00;
   logic       mouse_stb = 1'b0;
   logic [2:0] leds;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [7:0] rx_q[$];
   int         rx_t[$];

   kbd_responder #(.FIFO_DEPTH(8), .TX_GAP(4), .KBD_ID(8'h81)) dut (
      .clkcpu(clkcpu), .rst_n(rst_n),
      .kbd_out_data(kbd_out_data), .kbd_out_strobe(kbd_out_strobe),
      .kbd_in_data(kbd_in_data), .kbd_in_strobe(kbd_in_strobe),
      .key_valid(key_valid), .key_down(key_down), .key_row(key_row), .key_col(key_col),
      .key_ready(key_ready),
      .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .mouse_stb(mouse_stb),
      .leds(leds)
   );

   always #5 clkcpu = ~clkcpu;
   always @(posedge clkcpu) cyc <= cyc + 1;
   always @(negedge clkcpu) begin
      if (kbd_in_strobe) begin
         rx_q.push_back(kbd_in_data);
         rx_t.push_back(cyc);
      end
   end

   task automatic host_send(input logic [7:0] b);
      @(negedge clkcpu);
      kbd_out_data = b;
      kbd_out_strobe = 1'b1;
      @(negedge clkcpu);
      kbd_out_strobe = 1'b0;
   endtask

   task automatic push_key(input logic down, input logic [3:0] row, input logic [3:0] col);
      @(negedge clkcpu);
      key_valid = 1'b1; key_down = down; key_row = row; key_col = col;
      @(negedge clkcpu);
      key_valid = 1'b0;
   endtask

   task automatic get_byte(output logic [7:0] b, output int t, output bit ok);
      ok = 1'b0; b = 8'h00; t = 0;
      for (int i = 0; i < 300; i++) begin
         if (rx_q.size() != 0) begin
            b = rx_q.pop_front();
            t = rx_t.pop_front();
            ok = 1'b1;
            break;
         end
         @(negedge clkcpu);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clkcpu);
   endtask

   task automatic test_reset;
      wait_cycles(3);
      total++;
      if (kbd_in_data !== 8'h00 || kbd_in_strobe !== 1'b0 || leds !== 3'b000 || key_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_outputs got data=%h stb=%b leds=%b rdy=%b exp 00/0/000/1",
                  kbd_in_data, kbd_in_strobe, leds, key_ready);
      end
      rst_n = 1'b1;
      wait_cycles(2);
   endtask

   task automatic test_handshake;
      logic [7:0] b; int t1, t2, t3; bit ok;
      host_send(8'hFF); get_byte(b, t1, ok);
      total++; if (!ok || b !== 8'hFF) begin bad++; $display("FAIL hs_ff got=%h ok=%0d exp=ff", b, ok); end
      host_send(8'hFE); get_byte(b, t2, ok);
      total++; if (!ok || b !== 8'hFE) begin bad++; $display("FAIL hs_fe got=%h ok=%0d exp=fe", b, ok); end
      total++; if (t2 - t1 < 4) begin bad++; $display("FAIL hs_gap1 got=%0d exp>=4", t2 - t1); end
      host_send(8'hFD); get_byte(b, t3, ok);
      total++; if (!ok || b !== 8'hFD) begin bad++; $display("FAIL hs_fd got=%h ok=%0d exp=fd", b, ok); end
      total++; if (t3 - t2 < 4) begin bad++; $display("FAIL hs_gap2 got=%0d exp>=4", t3 - t2); end
   endtask

   task automatic test_leds_id;
      logic [7:0] b; int t; bit ok;
      host_send(8'h05); wait_cycles(12);
      total++; if (leds !== 3'b101) begin bad++; $display("FAIL leds got=%b exp=101", leds); end
      total++; if (rx_q.size() != 0) begin bad++; $display("FAIL leds_noreply got=%0d bytes exp=0", rx_q.size()); end
      host_send(8'h20); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'h81) begin bad++; $display("FAIL rqid got=%h ok=%0d exp=81", b, ok); end
   endtask

   task automatic test_key_press;
      logic [7:0] b; int t; bit ok;
      host_send(8'h33);
      push_key(1'b1, 4'd3, 4'd5); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hC3) begin bad++; $display("FAIL press_k1 got=%h ok=%0d exp=c3", b, ok); end
      host_send(8'h3F); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hC5) begin bad++; $display("FAIL press_k2 got=%h ok=%0d exp=c5", b, ok); end
      host_send(8'h31); wait_cycles(20);
      total++; if (rx_q.size() != 0 || key_ready !== 1'b1) begin
         bad++; $display("FAIL press_empty got=%0d bytes rdy=%b exp=0 bytes rdy=1", rx_q.size(), key_ready);
      end
   endtask

   task automatic test_key_release_resend;
      logic [7:0] b; int t; bit ok;
      push_key(1'b0, 4'd3, 4'd5); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hD3) begin bad++; $display("FAIL rel_k1 got=%h ok=%0d exp=d3", b, ok); end
      host_send(8'h21); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hD3) begin bad++; $display("FAIL rel_resend got=%h ok=%0d exp=d3", b, ok); end
      host_send(8'h3F); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hD5) begin bad++; $display("FAIL rel_k2 got=%h ok=%0d exp=d5", b, ok); end
      host_send(8'h31); wait_cycles(20);
      total++; if (rx_q.size() != 0) begin bad++; $display("FAIL rel_done got=%0d bytes exp=0", rx_q.size()); end
   endtask

   task automatic test_mouse;
      logic [7:0] b; int t; bit ok;
      @(negedge clkcpu);
      mouse_dx = 8'd50; mouse_dy = 8'hF6; mouse_stb = 1'b1;
      wait_cycles(2);
      mouse_stb = 1'b0;
      host_send(8'h32); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'h3F) begin bad++; $display("FAIL mouse_x got=%h ok=%0d exp=3f", b, ok); end
      host_send(8'h3F); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'h6C) begin bad++; $display("FAIL mouse_y got=%h ok=%0d exp=6c", b, ok); end
      host_send(8'h32); wait_cycles(30);
      total++; if (rx_q.size() != 0) begin bad++; $display("FAIL mouse_cleared got=%0d bytes exp=0", rx_q.size()); end
      host_send(8'h22); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'h00) begin bad++; $display("FAIL rqmp_x got=%h ok=%0d exp=00", b, ok); end
      host_send(8'h3F); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'h00) begin bad++; $display("FAIL rqmp_y got=%h ok=%0d exp=00", b, ok); end
      host_send(8'h32);
      @(negedge clkcpu);
      mouse_dx = 8'h9C; mouse_dy = 8'h64; mouse_stb = 1'b1;
      @(negedge clkcpu);
      mouse_stb = 1'b0;
      get_byte(b, t, ok);
      total++; if (!ok || b !== 8'h40) begin bad++; $display("FAIL sat_neg_x got=%h ok=%0d exp=40", b, ok); end
      host_send(8'h3F); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'h3F) begin bad++; $display("FAIL sat_pos_y got=%h ok=%0d exp=3f", b, ok); end
      host_send(8'h32); wait_cycles(20);
   endtask

   task automatic test_hrst_mid_report;
      logic [7:0] b; int t; bit ok;
      host_send(8'h31);
      push_key(1'b1, 4'd3, 4'd5); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hC3) begin bad++; $display("FAIL hrst_k1 got=%h ok=%0d exp=c3", b, ok); end
      host_send(8'hFF); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hFF) begin bad++; $display("FAIL hrst_reply got=%h ok=%0d exp=ff", b, ok); end
      wait_cycles(20);
      total++; if (rx_q.size() != 0 || key_ready !== 1'b1) begin
         bad++; $display("FAIL hrst_flush got=%0d bytes rdy=%b exp=0 bytes rdy=1", rx_q.size(), key_ready);
      end
      host_send(8'hFE); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hFE) begin bad++; $display("FAIL hrst_fe got=%h ok=%0d exp=fe", b, ok); end
      host_send(8'hFD); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hFD) begin bad++; $display("FAIL hrst_fd got=%h ok=%0d exp=fd", b, ok); end
   endtask

   task automatic test_fifo_full;
      logic [7:0] b; int t; bit ok;
      for (int i = 0; i < 9; i++) begin
         @(negedge clkcpu);
         key_valid = 1'b1; key_down = 1'b1; key_row = i[3:0]; key_col = 4'(i + 1);
         @(negedge clkcpu);
         key_valid = 1'b0;
         total++;
         if (key_ready !== ((i + 1) < 8)) begin
            bad++; $display("FAIL full_ready push=%0d got=%b exp=%b", i + 1, key_ready, ((i + 1) < 8));
         end
      end
      host_send(8'h31); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hC0) begin bad++; $display("FAIL full_head_k1 got=%h ok=%0d exp=c0", b, ok); end
      host_send(8'h3F); get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hC1) begin bad++; $display("FAIL full_head_k2 got=%h ok=%0d exp=c1", b, ok); end
      host_send(8'h31);
      total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL full_pop_ready got=%b exp=1", key_ready); end
      get_byte(b, t, ok);
      total++; if (!ok || b !== 8'hC1) begin bad++; $display("FAIL full_next_k1 got=%h ok=%0d exp=c1", b, ok); end
   endtask

   initial begin
      test_reset();
      test_handshake();
      test_leds_id();
      test_key_press();
      test_key_release_resend();
      test_mouse();
      test_hrst_mid_report();
      test_fifo_full();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
